// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between IFU (port 0) and LSU (port 1), one transaction in flight.
// Latency: accept -> mem_req_valid next cycle; zero-wait memory gives rsp_valid 3 cycles after accept.
// Backpressure: a losing or blocked requester sees req_ready=0 and holds; fields stay stable while mem_req_ready=0 or rsp_ready=0.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/ready/addr/wen/wdata/wmask   per-port request (port n at [n*W +: W])
//   rsp_valid/ready, rsp_rdata, rsp_err    response to the owning port only
//   mem_req_valid/ready, mem_addr/wen/wdata/wmask   registered request to memory
//   mem_rsp_valid/ready, mem_rdata, mem_err         memory response
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*AW-1:0] req_addr,
  input  logic [1:0]      req_wen,
  input  logic [2*DW-1:0] req_wdata,
  input  logic [2*MW-1:0] req_wmask,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [MW-1:0]   mem_wmask,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t     state, state_d;
  logic       owner;
  logic       last_grant;
  logic       stale;
  logic [7:0] timer;

  logic       grant;
  logic       winner;
  logic       timeout_hit;
  logic       drain;

  always_comb begin
    state_d       = state;
    req_ready     = '0;
    rsp_valid     = '0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    grant         = 1'b0;
    timeout_hit   = 1'b0;
    drain         = 1'b0;
    // Round robin on a tie: the port that did not win last time goes first.
    winner        = (&req_valid) ? ~last_grant : req_valid[1];

    case (state)
      IDLE: begin
        if (!stale && (|req_valid)) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_d           = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) begin
          state_d = RSP;
        end else if (timer == TLAST) begin
          timeout_hit = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A timed-out transaction may still answer later; swallow that response
    // outside WAIT so it is never mistaken for the next transaction's data.
    if (stale && state != WAIT) begin
      mem_rsp_ready = 1'b1;
      drain         = mem_rsp_valid;
    end

    if (rst) begin
      req_ready     = '0;
      rsp_valid     = '0;
      mem_req_valid = 1'b0;
      mem_rsp_ready = 1'b0;
      grant         = 1'b0;
      timeout_hit   = 1'b0;
      drain         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      stale      <= 1'b0;
      timer      <= '0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_d;

      if (grant) begin
        owner      <= winner;
        last_grant <= winner;
        mem_addr   <= winner ? req_addr[AW +: AW]  : req_addr[0 +: AW];
        mem_wen    <= winner ? req_wen[1]          : req_wen[0];
        mem_wdata  <= winner ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
        // Mask is meaningless for reads; keep it zero so the bus is quiet.
        if (winner ? req_wen[1] : req_wen[0])
          mem_wmask <= winner ? req_wmask[MW +: MW] : req_wmask[0 +: MW];
        else
          mem_wmask <= '0;
      end

      if (state == REQ && mem_req_ready) timer <= '0;

      if (state == WAIT) begin
        if (mem_rsp_valid) begin
          rsp_rdata <= mem_rdata;
          rsp_err   <= mem_err;
        end else if (timeout_hit) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
          stale     <= 1'b1;
        end else begin
          timer <= timer + 8'd1;
        end
      end

      if (drain) stale <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter (TIMEOUT=4).
// Latency: every check samples 2 time units after the rising edge.
// Backpressure: memory and owner ready are driven explicitly per vector.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_wen;
  logic [63:0] req_wdata;
  logic [15:0] req_wmask;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .MW(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check({tag, "_mem_rsp_ready"}, 64'(mem_rsp_ready), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
  endtask

  // Zero-wait read transaction; entered 1 unit after an edge in IDLE with req_valid driven.
  task automatic xact(input string tag, input logic [1:0] gnt, input logic [31:0] addr,
                      input logic [31:0] rdata);
    #1 check({tag, "_gnt"}, 64'(req_ready), 64'(gnt));
    tick();
    #1 check({tag, "_mreqv"}, 64'(mem_req_valid), 64'd1);
    check({tag, "_maddr"}, 64'(mem_addr), 64'(addr));
    check({tag, "_rspv_early"}, 64'(rsp_valid), 64'd0);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = rdata; mem_err = 1'b0;
    #1 check({tag, "_mrspr"}, 64'(mem_rsp_ready), 64'd1);
    tick();
    mem_rsp_valid = 1'b0; rsp_ready = gnt;
    #1 check({tag, "_rspv"}, 64'(rsp_valid), 64'(gnt));
    check({tag, "_rdata"}, 64'(rsp_rdata), 64'(rdata));
    check({tag, "_err"}, 64'(rsp_err), 64'd0);
    tick();
    rsp_ready = 2'b00;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_wen = '0; req_wdata = '0;
    req_wmask = '0; rsp_ready = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    mem_rdata = '0; mem_err = 1'b0;

    // Reset state
    do_reset();
    #1 check_idle_zero("reset");
    tick();

    // 1: IFU read, zero-wait memory, response 3 cycles after accept
    req_valid = 2'b01; req_addr[31:0] = 32'h8000_0000;
    xact("t1", 2'b01, 32'h8000_0000, 32'h0000_0413);
    req_valid = 2'b00;

    // 2: tie after reset goes LSU, then alternates while both hold
    do_reset();
    req_valid = 2'b11; req_addr[31:0] = 32'h0000_0100; req_addr[63:32] = 32'h0000_0200;
    xact("t2a", 2'b10, 32'h0000_0200, 32'h0000_0AAA);
    xact("t2b", 2'b01, 32'h0000_0100, 32'h0000_0BBB);
    xact("t2c", 2'b10, 32'h0000_0200, 32'h0000_0CCC);
    req_valid = 2'b00;

    // 3: LSU write, fields stable while memory stalls 5 cycles
    mem_req_ready = 1'b0;
    req_valid = 2'b10; req_wen = 2'b10; req_addr[63:32] = 32'h8000_0102;
    req_wdata[63:32] = 32'h0000_BEEF; req_wmask[15:8] = 8'h0C;
    #1 check("t3_gnt", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00; req_wen = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1 check("t3_mreqv", 64'(mem_req_valid), 64'd1);
      check("t3_mwen", 64'(mem_wen), 64'd1);
      check("t3_mwmask", 64'(mem_wmask), 64'h0C);
      check("t3_maddr", 64'(mem_addr), 64'h8000_0102);
      check("t3_mwdata", 64'(mem_wdata), 64'hBEEF);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_CAFE;
    tick();
    mem_rsp_valid = 1'b0; rsp_ready = 2'b10;
    #1 check("t3_rspv", 64'(rsp_valid), 64'd2);
    check("t3_rdata", 64'(rsp_rdata), 64'hCAFE);
    tick();
    rsp_ready = 2'b00;

    // 4: LSU read times out after 4 WAIT cycles; late response drained; IFU waits
    req_valid = 2'b10; req_addr[63:32] = 32'h0000_0040;
    #1 check("t4_gnt", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b01; req_addr[31:0] = 32'h0000_0080;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1 check("t4_wait_mrspr", 64'(mem_rsp_ready), 64'd1);
      check("t4_wait_rspv", 64'(rsp_valid), 64'd0);
      check("t4_wait_gnt", 64'(req_ready), 64'd0);
      tick();
    end
    #1 check("t4_rspv", 64'(rsp_valid), 64'd2);
    check("t4_err", 64'(rsp_err), 64'd1);
    check("t4_rdata", 64'(rsp_rdata), 64'd0);
    check("t4_drain_rdy_rsp", 64'(mem_rsp_ready), 64'd1);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    #1 check("t4_stale_gnt0", 64'(req_ready), 64'd0);
    check("t4_stale_rdy", 64'(mem_rsp_ready), 64'd1);
    tick();
    #1 check("t4_stale_gnt1", 64'(req_ready), 64'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_1111;
    #1 check("t4_stale_gnt2", 64'(req_ready), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    #1 check("t4_drained_rdy", 64'(mem_rsp_ready), 64'd0);
    check("t4_drained_rspv", 64'(rsp_valid), 64'd0);
    xact("t4_ifu", 2'b01, 32'h0000_0080, 32'h0000_0077);
    req_valid = 2'b00;

    // 5: LSU read with memory error, owner stalls response 3 cycles
    req_valid = 2'b10; req_addr[63:32] = 32'h0000_0300;
    #1 check("t5_gnt", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00;
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_DEAD; mem_err = 1'b1;
    tick();
    mem_rsp_valid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("t5_rspv", 64'(rsp_valid), 64'd2);
      check("t5_rdata", 64'(rsp_rdata), 64'hDEAD);
      check("t5_err", 64'(rsp_err), 64'd1);
      tick();
    end
    rsp_ready = 2'b10;
    #1 check("t5_rspv_acc", 64'(rsp_valid), 64'd2);
    tick();
    rsp_ready = 2'b00;
    #1 check("t5_done", 64'(rsp_valid), 64'd0);

    // 6: reset while in WAIT aborts to IDLE; next request works
    req_valid = 2'b01; req_addr[31:0] = 32'h0000_0500;
    #1 check("t6_gnt", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    tick();
    #1 check("t6_in_wait", 64'(mem_rsp_ready), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check_idle_zero("t6_after_rst");
    tick();
    req_valid = 2'b01; req_addr[31:0] = 32'h0000_0600;
    xact("t6_new", 2'b01, 32'h0000_0600, 32'h0000_0666);
    req_valid = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
